// File: rtl/rr_sel_secuenciador_4_pkg.sv
// Shared constants and FSM state type for the round-robin mux-select sequencer.
//   N_CH  : number of request channels feeding the 4:1 mux
//   SEL_W : width of the mux select / round-robin pointer
package rr_sel_secuenciador_4_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/rr_sel_secuenciador_4_if.sv
// Handshake/bus bundle between the sequencer and its environment.
//   i_en    : sequencer enable
//   i_req   : per-channel request, bit k = channel k has data
//   i_ready : downstream accepts the current beat
//   o_sel   : registered 4:1 mux select
//   o_grant : one-hot granted channel, 0 when none
//   o_valid : beat on the mux output is valid
//   o_wrap  : one-cycle pulse after a channel-3 burst ends
// master = environment side, slave = sequencer side.
interface rr_sel_secuenciador_4_if;
  import rr_sel_secuenciador_4_pkg::*;

  logic              i_en;
  logic [N_CH-1:0]   i_req;
  logic              i_ready;
  logic [SEL_W-1:0]  o_sel;
  logic [N_CH-1:0]   o_grant;
  logic              o_valid;
  logic              o_wrap;

  modport master (
    output i_en, i_req, i_ready,
    input  o_sel, o_grant, o_valid, o_wrap
  );

  modport slave (
    input  i_en, i_req, i_ready,
    output o_sel, o_grant, o_valid, o_wrap
  );

endinterface

// File: rtl/rr_prioridad_4.sv
// Combinational rotating-priority picker: first requesting channel scanning
// ptr, ptr+1, ... modulo N_CH.
//   req_i     : request vector
//   ptr_i     : channel with highest priority this scan
//   found_c_o : at least one request is set
//   idx_c_o   : index of the chosen channel (0 when none found)
module rr_prioridad_4
  import rr_sel_secuenciador_4_pkg::*;
(
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_c_o,
  output logic [SEL_W-1:0] idx_c_o
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    found_c_o = 1'b0;
    idx_c_o   = '0;
    cand      = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = ptr_i + SEL_W'(i);
      if (req_i[cand]) begin
        found_c_o = 1'b1;
        idx_c_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_secuenciador_4.sv
// Round-robin sequencer generating the select of the downstream 4:1 data mux.
// Grants one channel at a time for a burst of DWELL accepted beats.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : handshake bundle (slave side), see rr_sel_secuenciador_4_if
module rr_sel_secuenciador_4
  import rr_sel_secuenciador_4_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  rr_sel_secuenciador_4_if.slave  bus
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  logic             found_c;
  logic [SEL_W-1:0] idx_c;
  logic             accept_c;
  logic             burst_end_c;

  rr_prioridad_4 u_prioridad (
    .req_i     (bus.i_req),
    .ptr_i     (ptr_q),
    .found_c_o (found_c),
    .idx_c_o   (idx_c)
  );

  assign accept_c = valid_q & bus.i_ready;
  // Burst ends on its last accepted beat, or early when the granted request drops.
  assign burst_end_c = (accept_c && (cnt_q == '0)) || !bus.i_req[sel_q];

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_en && (|bus.i_req)) state_d = ARB;
      end
      ARB: begin
        if (found_c) begin
          sel_d   = idx_c;
          grant_d = N_CH'(1) << idx_c;
          cnt_d   = CW'(DWELL - 1);
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (burst_end_c) begin
          ptr_d   = sel_q + SEL_W'(1);
          valid_d = 1'b0;
          grant_d = '0;
          wrap_d  = (sel_q == SEL_W'(N_CH - 1));
          state_d = (bus.i_en && (|bus.i_req)) ? ARB : IDLE;
        end else if (accept_c) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.o_sel   = sel_q;
  assign bus.o_grant = grant_q;
  assign bus.o_valid = valid_q;
  assign bus.o_wrap  = wrap_q;

endmodule
